// File: rtl/pid_event_buffer.sv
// pid_event_buffer: timestamped particle-ID hit FIFO with local-bus register access.
// Optional per-flag rate counters at BASE+4..6 are compiled in with `define PID_EVT_RATE_COUNTERS_EN.
module pid_event_buffer #(
    parameter logic [7:0]  BASE       = 8'h40,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Result,
    input  logic        Electron,
    input  logic        Pion,
    input  logic        Muon,
    input  logic [31:0] DataIn,
    input  logic [7:0]  Address,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] DataOut,
    output logic        Irq
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned EW    = 51;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);

    localparam logic [7:0] A_STATUS = BASE;
    localparam logic [7:0] A_HEAD   = BASE + 8'd1;
    localparam logic [7:0] A_POP    = BASE + 8'd2;
    localparam logic [7:0] A_CTRL   = BASE + 8'd3;
`ifdef PID_EVT_RATE_COUNTERS_EN
    localparam logic [7:0] A_CNT_E  = BASE + 8'd4;
    localparam logic [7:0] A_CNT_P  = BASE + 8'd5;
    localparam logic [7:0] A_CNT_M  = BASE + 8'd6;
`endif

    logic [EW-1:0]         r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovf;
    logic                  r_cap_en;
    logic                  r_rd_prev;
    logic [15:0]           r_ts;

    logic          w_empty;
    logic          w_full;
    logic          w_push_req;
    logic          w_rd_pop;
    logic          w_pop_req;
    logic          w_do_pop;
    logic          w_do_push;
    logic          w_ovf_set;
    logic          w_flush;
    logic          w_ctrl_wr;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic          w_unused_din;

    assign w_unused_din = ^DataIn[31:2];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_push_req = (Result != '0) && r_cap_en;
    assign w_rd_pop   = Read && (Address == A_POP);
    assign w_pop_req  = w_rd_pop && !r_rd_prev;
    assign w_do_pop   = w_pop_req && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
    assign w_do_push  = w_push_req && (!w_full || w_do_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_do_pop;
    assign w_ctrl_wr  = Write && (Address == A_CTRL);
    assign w_flush    = w_ctrl_wr && DataIn[1];
    assign w_entry    = {Result, Electron, Pion, Muon, r_ts};
    assign w_head     = r_mem[r_rd_ptr];
    assign w_status   = {21'b0, r_ovf, w_full, w_empty, 8'(r_count)};
    assign Irq        = !w_empty;

    always_ff @(posedge clk) begin
        if (w_do_push && !w_flush) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_cap_en  <= 1'b1;
            r_rd_prev <= 1'b0;
            r_ts      <= '0;
        end else begin
            r_ts      <= r_ts + 16'd1;
            r_rd_prev <= w_rd_pop;
            if (w_ctrl_wr) begin
                r_cap_en <= DataIn[0];
            end
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                if (w_do_push && !w_do_pop) begin
                    r_count <= r_count + CNT_ONE;
                end else if (!w_do_push && w_do_pop) begin
                    r_count <= r_count - CNT_ONE;
                end
                if (w_ovf_set) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

`ifdef PID_EVT_RATE_COUNTERS_EN
    logic [31:0] r_cnt_e;
    logic [31:0] r_cnt_p;
    logic [31:0] r_cnt_m;
    logic        w_cnt_clr;

    assign w_cnt_clr = Write && (Address == A_CNT_E);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_e <= '0;
            r_cnt_p <= '0;
            r_cnt_m <= '0;
        end else if (w_cnt_clr) begin
            r_cnt_e <= '0;
            r_cnt_p <= '0;
            r_cnt_m <= '0;
        end else begin
            if (Electron && (r_cnt_e != '1)) r_cnt_e <= r_cnt_e + 32'd1;
            if (Pion     && (r_cnt_p != '1)) r_cnt_p <= r_cnt_p + 32'd1;
            if (Muon     && (r_cnt_m != '1)) r_cnt_m <= r_cnt_m + 32'd1;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        if (Read) begin
            case (Address)
                A_STATUS: w_rdata = w_status;
                A_HEAD:   w_rdata = w_empty ? '0 : w_head[50:19];
                A_POP:    w_rdata = w_empty ? '0 : {13'b0, w_head[18:0]};
                A_CTRL:   w_rdata = {31'b0, r_cap_en};
`ifdef PID_EVT_RATE_COUNTERS_EN
                A_CNT_E:  w_rdata = r_cnt_e;
                A_CNT_P:  w_rdata = r_cnt_p;
                A_CNT_M:  w_rdata = r_cnt_m;
`endif
                default:  w_rdata = '0;
            endcase
        end
    end

    assign DataOut = rst ? w_rdata : '0;

endmodule

// File: tb/tb_pid_event_buffer.sv
// Self-checking bench for pid_event_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the event FIFO and register map.
module tb_pid_event_buffer;
    localparam logic [7:0] BASE = 8'h40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] Result = '0;
    logic        Electron = 1'b0;
    logic        Pion = 1'b0;
    logic        Muon = 1'b0;
    logic [31:0] DataIn = '0;
    logic [7:0]  Address = '0;
    logic        Read = 1'b0;
    logic        Write = 1'b0;
    logic [31:0] DataOut;
    logic        Irq;

    pid_event_buffer #(.BASE(BASE), .DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .Result(Result), .Electron(Electron), .Pion(Pion),
        .Muon(Muon), .DataIn(DataIn), .Address(Address), .Read(Read), .Write(Write),
        .DataOut(DataOut), .Irq(Irq)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        e;
        logic        p;
        logic        m;
        logic [15:0] ts;
    } ev_t;

    ev_t         m_q[$];
    logic        m_ovf;
    logic        m_cap;
    logic        m_prev_sel;
    logic [15:0] m_ts;
    logic [31:0] m_cnt[3];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic void model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_cap = 1'b1;
        m_prev_sel = 1'b0;
        m_ts = '0;
        for (int i = 0; i < 3; i++) m_cnt[i] = '0;
    endfunction

    // One clock edge of the FIFO's behaviour, from the inputs present at that edge.
    function automatic void model_step();
        bit  push, sel, pop, flush;
        ev_t ev;
        push  = (Result != 0) && m_cap;
        sel   = Read && (Address == BASE + 8'd2);
        pop   = sel && !m_prev_sel && (m_q.size() > 0);
        flush = Write && (Address == BASE + 8'd3) && DataIn[1];
        ev.res = Result; ev.e = Electron; ev.p = Pion; ev.m = Muon; ev.ts = m_ts;
        if (flush) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < 16) m_q.push_back(ev);
                else m_ovf = 1'b1;
            end
        end
        if (Write && (Address == BASE + 8'd3)) m_cap = DataIn[0];
        m_ts = m_ts + 16'd1;
        m_prev_sel = sel;
`ifdef PID_EVT_RATE_COUNTERS_EN
        if (Write && (Address == BASE + 8'd4)) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = '0;
        end else begin
            if (Electron && m_cnt[0] != 32'hFFFF_FFFF) m_cnt[0] = m_cnt[0] + 32'd1;
            if (Pion     && m_cnt[1] != 32'hFFFF_FFFF) m_cnt[1] = m_cnt[1] + 32'd1;
            if (Muon     && m_cnt[2] != 32'hFFFF_FFFF) m_cnt[2] = m_cnt[2] + 32'd1;
        end
`endif
    endfunction

    function automatic logic [31:0] exp_dataout();
        int n;
        n = m_q.size();
        if (!Read || !rst) return '0;
        if (Address == BASE)
            return {21'b0, m_ovf, (n == 16), (n == 0), 8'(n)};
        if (Address == BASE + 8'd1) return (n > 0) ? m_q[0].res : '0;
        if (Address == BASE + 8'd2)
            return (n > 0) ? {13'b0, m_q[0].e, m_q[0].p, m_q[0].m, m_q[0].ts} : '0;
        if (Address == BASE + 8'd3) return {31'b0, m_cap};
`ifdef PID_EVT_RATE_COUNTERS_EN
        if (Address == BASE + 8'd4) return m_cnt[0];
        if (Address == BASE + 8'd5) return m_cnt[1];
        if (Address == BASE + 8'd6) return m_cnt[2];
`endif
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic idle_bus();
        Read = 1'b0; Write = 1'b0; Address = BASE; DataIn = '0;
        Result = '0; Electron = 1'b0; Pion = 1'b0; Muon = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        Read = 1'b1; Address = BASE;
        #5;
        n_checks++;
        if (DataOut !== 32'h0) begin n_errors++; $display("FAIL reset_dataout: got %h want %h", DataOut, 32'h0); end
        n_checks++;
        if (Irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b want 0", Irq); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (DataOut !== 32'h100) begin n_errors++; $display("FAIL reset_status: got %h want %h", DataOut, 32'h100); end
        Address = BASE + 8'd3; #1;
        n_checks++;
        if (DataOut !== 32'h1) begin n_errors++; $display("FAIL reset_ctrl: got %h want %h", DataOut, 32'h1); end
        Address = BASE + 8'd4; #1;
        n_checks++;
        if (DataOut !== 32'h0) begin n_errors++; $display("FAIL reset_cnt: got %h want %h", DataOut, 32'h0); end
        idle_bus();
    endtask

    task automatic test_single();
        logic [15:0] t;
        Result = 32'h0000_0100; Pion = 1'b1;
        t = m_ts;
        tick();
        Result = '0; Pion = 1'b0;
        Read = 1'b1; Address = BASE; #1;
        n_checks++;
        if (DataOut !== 32'h001) begin n_errors++; $display("FAIL single_status: got %h want %h", DataOut, 32'h001); end
        n_checks++;
        if (Irq !== 1'b1) begin n_errors++; $display("FAIL single_irq: got %b want 1", Irq); end
        Address = BASE + 8'd1; #1;
        n_checks++;
        if (DataOut !== 32'h100) begin n_errors++; $display("FAIL single_head: got %h want %h", DataOut, 32'h100); end
        Address = BASE + 8'd2; #1;
        n_checks++;
        if (DataOut !== (32'h0002_0000 | {16'h0, t})) begin
            n_errors++; $display("FAIL single_pop: got %h want %h", DataOut, 32'h0002_0000 | {16'h0, t});
        end
        tick();
        Address = BASE; #1;
        n_checks++;
        if (DataOut !== 32'h100) begin n_errors++; $display("FAIL single_after: got %h want %h", DataOut, 32'h100); end
        idle_bus();
        tick();
    endtask

    task automatic test_overflow();
        logic [31:0] vals[17];
        for (int i = 0; i < 17; i++) begin
            vals[i] = $urandom | 32'h1;
            Result = vals[i];
            tick();
        end
        Result = '0;
        Read = 1'b1; Address = BASE; #1;
        n_checks++;
        if (DataOut !== 32'h610) begin n_errors++; $display("FAIL ovf_status: got %h want %h", DataOut, 32'h610); end
        for (int i = 0; i < 16; i++) begin
            Read = 1'b1; Address = BASE + 8'd1; #1;
            n_checks++;
            if (DataOut !== vals[i]) begin n_errors++; $display("FAIL ovf_order[%0d]: got %h want %h", i, DataOut, vals[i]); end
            Address = BASE + 8'd2;
            tick();
            Read = 1'b0;
            tick();
        end
        Read = 1'b1; Address = BASE; #1;
        n_checks++;
        if (DataOut !== 32'h500) begin n_errors++; $display("FAIL ovf_drained: got %h want %h", DataOut, 32'h500); end
        Read = 1'b0; Write = 1'b1; Address = BASE + 8'd3; DataIn = 32'h3;
        tick();
        idle_bus();
        Read = 1'b1; #1;
        n_checks++;
        if (DataOut !== 32'h100) begin n_errors++; $display("FAIL ovf_flushed: got %h want %h", DataOut, 32'h100); end
        idle_bus();
    endtask

    task automatic test_full_push_pop();
        logic [31:0] vals[17];
        for (int i = 0; i < 16; i++) begin
            vals[i] = $urandom | 32'h1;
            Result = vals[i];
            tick();
        end
        vals[16] = $urandom | 32'h1;
        Result = vals[16]; Read = 1'b1; Address = BASE + 8'd2;
        tick();
        Result = '0; Read = 1'b0;
        tick();
        Read = 1'b1; Address = BASE; #1;
        n_checks++;
        if (DataOut !== 32'h210) begin n_errors++; $display("FAIL fullpp_status: got %h want %h", DataOut, 32'h210); end
        for (int i = 1; i < 17; i++) begin
            Read = 1'b1; Address = BASE + 8'd1; #1;
            n_checks++;
            if (DataOut !== vals[i]) begin n_errors++; $display("FAIL fullpp_order[%0d]: got %h want %h", i, DataOut, vals[i]); end
            Address = BASE + 8'd2;
            tick();
            Read = 1'b0;
            tick();
        end
        idle_bus();
    endtask

    task automatic test_held_read();
        Result = 32'hA5;  tick();
        Result = 32'h5A;  tick();
        Result = '0;
        Read = 1'b1; Address = BASE + 8'd2;
        tick(); tick(); tick();
        Address = BASE; #1;
        n_checks++;
        if (DataOut !== 32'h001) begin n_errors++; $display("FAIL held_read: got %h want %h", DataOut, 32'h001); end
        Address = BASE + 8'd1; #1;
        n_checks++;
        if (DataOut !== 32'h5A) begin n_errors++; $display("FAIL held_head: got %h want %h", DataOut, 32'h5A); end
        Read = 1'b0; tick();
        Read = 1'b1; Address = BASE + 8'd2; tick();
        idle_bus(); tick();
    endtask

    task automatic test_flush_ctrl();
        for (int i = 0; i < 3; i++) begin Result = 32'h10 + i; tick(); end
        Result = 32'hDEAD; Write = 1'b1; Address = BASE + 8'd3; DataIn = 32'h2;
        tick();
        idle_bus();
        Read = 1'b1; #1;
        n_checks++;
        if (DataOut !== 32'h100) begin n_errors++; $display("FAIL flush_status: got %h want %h", DataOut, 32'h100); end
        n_checks++;
        if (Irq !== 1'b0) begin n_errors++; $display("FAIL flush_irq: got %b want 0", Irq); end
        Read = 1'b0; Write = 1'b1; Address = BASE + 8'd3; DataIn = 32'h0;
        tick();
        idle_bus();
        for (int i = 0; i < 4; i++) begin Result = 32'h77 + i; tick(); end
        Result = '0;
        Read = 1'b1; #1;
        n_checks++;
        if (DataOut !== 32'h100) begin n_errors++; $display("FAIL nocap_status: got %h want %h", DataOut, 32'h100); end
        Address = BASE + 8'd3; #1;
        n_checks++;
        if (DataOut !== 32'h0) begin n_errors++; $display("FAIL nocap_ctrl: got %h want %h", DataOut, 32'h0); end
        Read = 1'b0; Write = 1'b1; DataIn = 32'h1;
        tick();
        idle_bus();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin Result = $urandom | 32'h1; tick(); end
        Result = '0; Write = 1'b1; Address = BASE + 8'd3; DataIn = 32'h0;
        tick();
        idle_bus();
        Read = 1'b1; Address = BASE;
        #3 rst = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (Irq !== 1'b0) begin n_errors++; $display("FAIL midrst_irq: got %b want 0", Irq); end
        n_checks++;
        if (DataOut !== 32'h0) begin n_errors++; $display("FAIL midrst_dataout: got %h want %h", DataOut, 32'h0); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (DataOut !== 32'h100) begin n_errors++; $display("FAIL midrst_status: got %h want %h", DataOut, 32'h100); end
        Address = BASE + 8'd3; #1;
        n_checks++;
        if (DataOut !== 32'h1) begin n_errors++; $display("FAIL midrst_ctrl: got %h want %h", DataOut, 32'h1); end
        idle_bus();
    endtask

    task automatic test_random();
        logic [31:0] wd;
        logic [31:0] want;
        int          op;
        for (int c = 0; c < 600; c++) begin
            idle_bus();
            Result   = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
            Electron = 1'($urandom_range(0, 1));
            Pion     = 1'($urandom_range(0, 1));
            Muon     = 1'($urandom_range(0, 1));
            op = int'($urandom_range(0, 11));
            if (op <= 6) begin
                Read = 1'b1;
                Address = BASE + 8'($urandom_range(0, 7));
            end else if (op == 7) begin
                wd = $urandom;
                wd[0] = ($urandom_range(0, 3) != 0);
                wd[1] = ($urandom_range(0, 7) == 0);
                Write = 1'b1; Address = BASE + 8'd3; DataIn = wd;
            end else if (op == 8) begin
                Write = 1'b1; Address = BASE + 8'($urandom_range(4, 6)); DataIn = $urandom;
            end
            #1;
            want = exp_dataout();
            n_checks++;
            if (DataOut !== want) begin n_errors++; $display("FAIL rand_dataout[%0d]: addr %h got %h want %h", c, Address, DataOut, want); end
            n_checks++;
            if (Irq !== (m_q.size() != 0)) begin n_errors++; $display("FAIL rand_irq[%0d]: got %b want %b", c, Irq, m_q.size() != 0); end
            tick();
        end
        idle_bus();
        Write = 1'b1; Address = BASE + 8'd3; DataIn = 32'h3;
        tick();
        idle_bus();
    endtask

    task automatic test_counters();
        logic [31:0] want;
        Write = 1'b1; Address = BASE + 8'd4; DataIn = '0;
        tick();
        idle_bus();
        for (int i = 0; i < 5; i++) begin
            Electron = 1'b1; tick();
            Electron = 1'b0; tick();
        end
`ifdef PID_EVT_RATE_COUNTERS_EN
        want = 32'd5;
`else
        want = 32'd0;
`endif
        Read = 1'b1; Address = BASE + 8'd4; #1;
        n_checks++;
        if (DataOut !== want) begin n_errors++; $display("FAIL cnt_e: got %h want %h", DataOut, want); end
        Read = 1'b0; Write = 1'b1;
        tick();
        Write = 1'b0; Read = 1'b1; #1;
        n_checks++;
        if (DataOut !== 32'h0) begin n_errors++; $display("FAIL cnt_clear: got %h want %h", DataOut, 32'h0); end
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_held_read();
        test_flush_ctrl();
        test_mid_reset();
        test_random();
        test_counters();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pid_event_buffer.md
PID_EVENT_BUFFER -- requirements
Module: pid_event_buffer

Interface
REQ-001 Parameter BASE, default 8'h40, local-bus base address; block decodes BASE+0 .. BASE+6.
REQ-002 Parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 entries (16).
REQ-003 clk  in  1  50 MHz fabric clock; the same clock that drives Result and the particle flags.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 Result  in  32  decoded leading-edge hit word from the fine-time stage, one word per clk.
REQ-006 Electron, Pion, Muon  in  1 each  window-match flags, cycle-aligned with Result.
REQ-007 DataIn  in  32  local-bus write data.
REQ-008 Address  in  8  local-bus address.
REQ-009 Read, Write  in  1 each  local-bus strobes, level, synchronous to clk.
REQ-010 DataOut  out  32  read data; zero when not addressed, so it can be OR-combined on the bus.
REQ-011 Irq  out  1  high while the FIFO is non-empty.

Function
REQ-012 A 16-bit free-running timestamp increments every clk and wraps 16'hFFFF->0.
REQ-013 Push condition: Result != 0 and capture enabled (CTRL[0]); entry = {Result, Electron, Pion, Muon, timestamp of that cycle}.
REQ-014 Pushed entry visible at head one clk after the capture cycle; the head is held (no fall-through bypass beyond that one cycle).
REQ-015 Map, BASE+0 (R): STATUS = {overflow[10], full[9], empty[8], occupancy[4:0]}.
REQ-016 Map, BASE+1 (R): head Result; reads 0 when empty; no side effect.
REQ-017 Map, BASE+2 (R): {13'b0, E, P, M at [18:16], timestamp[15:0]}; reads 0 when empty; this read pops.
REQ-018 Pop fires once per Read assertion at BASE+2, on the first cycle Read is high (rising-edge detected); pop on empty is ignored.
REQ-019 Map, BASE+3 (R/W): CTRL; bit0 capture enable, reset value 1; writing bit1=1 flushes the FIFO and clears overflow (self-clearing, reads 0).
REQ-020 DataOut is combinational from Address/Read and is valid in the same cycle as Read.
REQ-021 Full: a push is dropped, the FIFO is unchanged, and the sticky overflow flag is set.
REQ-022 Push and pop in the same cycle while full: pop is performed and the push is accepted; occupancy stays 16 and overflow is not set.
REQ-023 Push and pop in the same cycle while empty: the push is accepted and the pop is ignored.
REQ-024 A flush in the same cycle as a push: the flush wins and the FIFO ends empty.
REQ-025 Write-pointer and read-pointer arithmetic is modulo 16; occupancy ranges 0..16.

Reset
REQ-026 While rst is low, all of the following clear asynchronously: pointers, occupancy, overflow, timestamp, and the edge-detect register.
REQ-027 While rst is low, CTRL resets to 32'h1, Irq=0, and DataOut=0.
REQ-028 Reset mid-operation discards all entries; FIFO RAM contents need not clear.

Configuration
REQ-029 Macro PID_EVT_RATE_COUNTERS_EN compiles in three 32-bit saturating counters for the E, P, and M flags, readable at BASE+4/5/6.
REQ-030 These counters increment on any cycle their flag is high, independent of capture enable and FIFO full.
REQ-031 A write to BASE+4 clears all three counters.
REQ-032 Without the macro, BASE+4..6 read 0, writes to them are ignored, and no counter logic is present.

Verification
REQ-033 Reset, then a single Result=32'h0000_0100 with Pion=1 at timestamp T -> STATUS=0x001, BASE+1=0x100, BASE+2=0x0002_0000|T; after the read, STATUS=0x100.
REQ-034 17 consecutive nonzero Results with no reads -> STATUS=0x600 | 16; the 17th entry is lost; reading the entries back gives the first 16 in order.
REQ-035 FIFO full, simultaneous push and BASE+2 pop -> occupancy stays 16, overflow stays 0, and the new entry appears last.
REQ-036 Read held high for 3 cycles at BASE+2 with 2 entries stored -> exactly one pop; occupancy=1.
REQ-037 Write CTRL=0x2 while pushing -> STATUS=0x100 and Irq=0; write CTRL=0x0 -> nonzero Results do not push.
REQ-038 With PID_EVT_RATE_COUNTERS_EN: 5 Electron pulses -> BASE+4 reads 5; after a write to BASE+4 it reads 0. Without the macro: BASE+4 reads 0.
